frq_meter: RTL and testbench
============================

Name: frq_meter

Overview:
- Measures the period of an incoming square wave in system-clock cycles; the inverse of the team's fixed-ratio clock dividers.
- Sits beside the piano tone path.
- Checks divided note clocks in hardware; reports the measured period on a valid strobe.
- Flags loss of signal via timeout.

Parameters:
- CNT_W, 20: width of period counter/output; must hold TIMEOUT.
- TIMEOUT, 1000000: cycles without a rising edge before declaring signal lost.
- SYNC_STAGES, 2: synchronizer flop count on sig_in (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous square wave under measurement.
- period  output  CNT_W  last measured period in clk cycles.
- period_valid  output  1  one-cycle strobe when period updates.
- timeout  output  1  high while the signal is considered lost.
- busy  output  1  high in MEASURE state.

Behaviour:
- Reset: on rst high, immediately and asynchronously clear the following.
  - Synchronizer flops, edge history, cnt, period, period_valid, busy: 0.
  - timeout: 1 (no signal known). State: IDLE.
- Sync/edge detect:
  - sig_in passes through SYNC_STAGES flops, then one history flop.
  - rise = synced & ~history.
  - Latency from an sig_in edge to rise: SYNC_STAGES+1 cycles.
  - Constant latency, so it cancels out of period measurement.
- FSM IDLE:
  - cnt holds 1; busy=0.
  - On rise: go to MEASURE, cnt<=1. No valid strobe on the first edge.
- FSM MEASURE:
  - busy=1; cnt increments by 1 each cycle.
  - Edge at cycle t0, next edge at t0+N: at t0+N, period<=N, period_valid<=1 for one cycle, timeout<=0, cnt<=1, stay in MEASURE.
- Timeout:
  - In MEASURE, if cnt==TIMEOUT and no rise this cycle: state<=IDLE, timeout<=1, period<=0, period_valid<=1 (one strobe announcing loss).
  - cnt never exceeds TIMEOUT; no wrap-around.
- Simultaneous rise and cnt==TIMEOUT: rise wins; period<=TIMEOUT, valid strobe, timeout<=0.
- Outputs:
  - period holds its value between strobes.
  - period_valid is never high two consecutive cycles except for back-to-back period=1 edges. These cannot occur: minimum detectable period is 2 because rise requires a low sample.
- Reset mid-measurement: aborts; the next measurement starts from IDLE, first edge again discarded.
- Glitches shorter than one clk may be missed; no filtering beyond synchronization.

Optional Feature:
- Macro HIGH_TIME_EN.
- When defined:
  - Adds output high_time[CNT_W-1:0], reset 0.
  - Adds a second counter that counts cycles while synced sig_in is high, cleared on rise.
  - On the falling edge of synced sig_in in MEASURE, high_time <= high count.
  - On each period_valid strobe, high_time is unchanged; on a timeout strobe, high_time <= 0.
  - Duty = high_time/period, computed by software.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset held, sig_in toggling -> period=0, period_valid=0, timeout=1, busy=0; deassert, first rise -> busy=1, no strobe.
- sig_in toggles every 500 clk (divide-by-1000 output) -> after second rise, period=1000, one-cycle strobe per 1000 clk, timeout=0.
- Period 2 (toggle every clk), then period 7 -> period=2 strobes every 2 cycles, then period=7.
- TIMEOUT=50 override, one rise then sig_in static -> cnt reaches 50, strobe with period=0, timeout=1, state IDLE; a new rise re-arms without a strobe.
- TIMEOUT=50, rise exactly on cnt==50 cycle -> period=50, timeout=0, stays MEASURE.
- HIGH_TIME_EN, sig_in 300 high / 700 low -> period=1000, high_time=300; rst asserted mid-period -> all outputs at reset values immediately.

Source files
------------

// File: rtl/frq_meter.sv
// frq_meter: measures sig_in period in clk cycles with loss-of-signal timeout; define HIGH_TIME_EN to add the high_time output
module frq_meter #(
    parameter int CNT_W       = 20,
    parameter int TIMEOUT     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
`ifdef HIGH_TIME_EN
    output logic [CNT_W-1:0] high_time,
`endif
    output logic             busy
);
    typedef enum logic {IDLE, MEASURE} state_t;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, busy_d;
    logic                   synced, rise, lost;
`ifdef HIGH_TIME_EN
    logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   fall;
`endif
    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~hist_q;
    assign lost   = (state_q == MEASURE) && !rise && (cnt_q == TMO);
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
        hist_d    = synced;
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (state_q == IDLE) begin
            cnt_d   = ONE;
            state_d = rise ? MEASURE : IDLE;
        end else if (rise) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = ONE;
        end else if (lost) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            period_d  = '0;
            valid_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + ONE;
        end
        busy_d = (state_d == MEASURE);
    end
`ifdef HIGH_TIME_EN
    assign fall = ~synced & hist_q;
    // high count saturates so a long static-high input in IDLE cannot wrap it
    always_comb begin
        hi_cnt_d    = rise ? ONE : (synced && hi_cnt_q != TMO) ? hi_cnt_q + ONE : hi_cnt_q;
        high_time_d = lost ? '0 : (state_q == MEASURE && fall) ? hi_cnt_q : high_time_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt_q    <= '0;
            high_time_q <= '0;
        end else begin
            hi_cnt_q    <= hi_cnt_d;
            high_time_q <= high_time_d;
        end
    end
    assign high_time = high_time_q;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            hist_q    <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end
    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_frq_meter.sv
// tb_frq_meter: directed checks of frq_meter with default and TIMEOUT=50 instances
module tb_frq_meter;
    logic        clk = 1'b0, rst = 1'b0, sig_a = 1'b0, sig_b = 1'b0;
    logic [19:0] period_a, period_b;
    logic        valid_a, valid_b, tmo_a, tmo_b, busy_a, busy_b;
`ifdef HIGH_TIME_EN
    logic [19:0] ht_a, ht_b;
`endif
    int errors = 0, checks = 0, n = 0, bad = 0;

    always #5 clk = ~clk;

    frq_meter dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_a), .period(period_a), .period_valid(valid_a),
        .timeout(tmo_a),
`ifdef HIGH_TIME_EN
        .high_time(ht_a),
`endif
        .busy(busy_a)
    );

    frq_meter #(.TIMEOUT(50)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_b), .period(period_b), .period_valid(valid_b),
        .timeout(tmo_b),
`ifdef HIGH_TIME_EN
        .high_time(ht_b),
`endif
        .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("async_rst_period", 32'(period_a), 0);
        check("async_rst_valid", 32'(valid_a), 0);
        check("async_rst_timeout", 32'(tmo_a), 1);
        check("async_rst_busy", 32'(busy_a), 0);
        for (int i = 0; i < 10; i++) begin
            sig_a = ~sig_a;
            tick;
        end
        check("rst_held_period", 32'(period_a), 0);
        check("rst_held_valid", 32'(valid_a), 0);
        check("rst_held_timeout", 32'(tmo_a), 1);
        check("rst_held_busy", 32'(busy_a), 0);
`ifdef HIGH_TIME_EN
        check("rst_held_high_time", 32'(ht_a), 0);
`endif
        rst = 1'b0;
        sig_a = 1'b0;
        repeat (5) tick;
        check("idle_busy", 32'(busy_a), 0);

        // period 1000: rises driven at 0,1000,2000,3000; strobes land 2 samples later
        n = 0; bad = 0;
        for (int i = 0; i < 3500; i++) begin
            sig_a = (i % 1000) < 500;
            tick;
            if (i == 1) check("first_rise_not_busy_yet", 32'(busy_a), 0);
            if (i == 2) check("first_rise_busy", 32'(busy_a), 1);
            if (i == 1001) check("timeout_before_first_period", 32'(tmo_a), 1);
            if (i == 1002) check("p1000_first_strobe", 32'(valid_a), 1);
            if (valid_a) begin
                n++;
                if (period_a != 20'd1000 || i < 1000 || i % 1000 != 2) bad++;
            end
        end
        check("p1000_strobe_count", 32'(n), 3);
        check("p1000_bad_strobes", 32'(bad), 0);
        check("p1000_period_held", 32'(period_a), 1000);
        check("p1000_timeout", 32'(tmo_a), 0);
        check("p1000_valid_low", 32'(valid_a), 0);

        n = 0; bad = 0;
        for (int j = 0; j < 40; j++) begin
            sig_a = (j % 2) == 0;
            tick;
            if (j >= 10) begin
                if (valid_a) n++;
                if (valid_a != ((j % 2) == 0) || (valid_a && period_a != 20'd2)) bad++;
            end
        end
        check("p2_strobe_count", 32'(n), 15);
        check("p2_bad_strobes", 32'(bad), 0);
        check("p2_period", 32'(period_a), 2);

        n = 0; bad = 0;
        for (int k = 0; k < 70; k++) begin
            sig_a = (k % 7) < 3;
            tick;
            if (k >= 5) begin
                if (valid_a) n++;
                if (valid_a != ((k % 7) == 2) || (valid_a && period_a != 20'd7)) bad++;
            end
        end
        check("p7_strobe_count", 32'(n), 9);
        check("p7_bad_strobes", 32'(bad), 0);
        check("p7_period", 32'(period_a), 7);

        // TIMEOUT=50: three period-10 rises, then static low until loss
        n = 0;
        for (int m = 0; m < 100; m++) begin
            sig_b = (m < 30) && ((m % 10) < 5);
            tick;
            if (valid_b) n++;
            if (m == 22) check("b_p10_period", 32'(period_b), 10);
            if (m == 22) check("b_p10_timeout", 32'(tmo_b), 0);
            if (m == 71) begin
                check("b_pre_loss_timeout", 32'(tmo_b), 0);
                check("b_pre_loss_busy", 32'(busy_b), 1);
                check("b_pre_loss_valid", 32'(valid_b), 0);
`ifdef HIGH_TIME_EN
                check("b_pre_loss_high_time", 32'(ht_b), 5);
`endif
            end
            if (m == 72) begin
                check("b_loss_valid", 32'(valid_b), 1);
                check("b_loss_period", 32'(period_b), 0);
                check("b_loss_timeout", 32'(tmo_b), 1);
                check("b_loss_busy", 32'(busy_b), 0);
`ifdef HIGH_TIME_EN
                check("b_loss_high_time", 32'(ht_b), 0);
`endif
            end
            if (m == 73) check("b_loss_strobe_one_cycle", 32'(valid_b), 0);
        end
        check("b_loss_strobe_count", 32'(n), 3);

        // re-arm without strobe, then a rise exactly on the cnt==TIMEOUT cycle
        n = 0;
        for (int q = 0; q < 60; q++) begin
            sig_b = (q < 25) || (q >= 50);
            tick;
            if (valid_b) n++;
            if (q == 2) check("b_rearm_busy", 32'(busy_b), 1);
            if (q == 10) check("b_rearm_timeout_kept", 32'(tmo_b), 1);
            if (q == 52) begin
                check("b_edge_tmo_valid", 32'(valid_b), 1);
                check("b_edge_tmo_period", 32'(period_b), 50);
                check("b_edge_tmo_timeout", 32'(tmo_b), 0);
                check("b_edge_tmo_busy", 32'(busy_b), 1);
`ifdef HIGH_TIME_EN
                check("b_edge_tmo_high_time", 32'(ht_b), 25);
`endif
            end
            if (q == 53) check("b_edge_tmo_still_busy", 32'(busy_b), 1);
        end
        check("b_rearm_strobe_count", 32'(n), 1);

        // 300 high / 700 low
        for (int p = 0; p < 2500; p++) begin
            sig_a = (p % 1000) < 300;
            tick;
            if (p == 1002 || p == 2002) begin
                check("duty_valid", 32'(valid_a), 1);
                check("duty_period", 32'(period_a), 1000);
`ifdef HIGH_TIME_EN
                check("duty_high_time", 32'(ht_a), 300);
`endif
            end
        end
        check("mid_period_busy", 32'(busy_a), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_period", 32'(period_a), 0);
        check("mid_rst_valid", 32'(valid_a), 0);
        check("mid_rst_timeout", 32'(tmo_a), 1);
        check("mid_rst_busy", 32'(busy_a), 0);
        check("mid_rst_b_period", 32'(period_b), 0);
        check("mid_rst_b_timeout", 32'(tmo_b), 1);
`ifdef HIGH_TIME_EN
        check("mid_rst_high_time", 32'(ht_a), 0);
`endif
        tick;
        rst = 1'b0;
        n = 0;
        for (int r = 0; r < 10; r++) begin
            sig_a = 1'b1;
            tick;
            if (valid_a) n++;
            if (r == 2) check("post_rst_first_rise_busy", 32'(busy_a), 1);
        end
        check("post_rst_no_strobe", 32'(n), 0);
        check("post_rst_period", 32'(period_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
